dac_responder: RTL and testbench
================================

# dac_responder

Synthesizable SPI responder that models the DAC end of the board's 4-channel DAC serial link, so the DAC-driving logic can be checked in simulation and in loopback on hardware. It samples SPI_SCK, SPI_MOSI, DAC_CS and DAC_CLR in the CLK50MHZ domain and decodes each 32-bit frame into per-channel input and output registers. It echoes the previous frame on DAC_OUT and reports every decoded frame on a one-cycle strobe.

## Interface
- SYNC_STAGES, 2: synchronizer depth on SPI_SCK, SPI_MOSI, DAC_CS and DAC_CLR (legal 2..3).
- RESET_CODE, 12'h000: value loaded into every input and DAC register on reset and on clear.

- CLK50MHZ  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- SPI_SCK  in  1  serial clock from the master; idles low.
- SPI_MOSI  in  1  serial data from the master; sampled on the SCK rising edge.
- DAC_CS  in  1  chip select, active-low; frames one transfer.
- DAC_CLR  in  1  clear, active-low.
- DAC_OUT  out  1  serial echo (MISO); changes after the SCK falling edge.
- dac_value  out  48  four 12-bit DAC output registers: [11:0]=A, [23:12]=B, [35:24]=C, [47:36]=D.
- pwrdn  out  4  per-channel power-down flags, bit0=A.
- frame_valid  out  1  one-cycle pulse when a legal frame is executed.
- frame_err  out  1  one-cycle pulse when CS rises with a bit count other than 32.
- frame_cmd  out  4  command field of the last legal frame.
- frame_addr  out  4  address field of the last legal frame.
- frame_data  out  12  data field of the last legal frame.

## Operation
- Frame word W[31:0] is received MSB first:
  - W[31:28]: don't-care.
  - W[27:16]: data.
  - W[15:12]: address.
  - W[11:8]: command.
  - W[7:0]: don't-care.
- Address: 0..3 selects A..D; 4'hF selects all four channels; any other value makes the frame a no-op but frame_valid still pulses.
- Commands:
  - 4'h0: write input register.
  - 4'h1: copy the input register to the DAC register.
  - 4'h2: write input register, then update all DAC registers from their input registers.
  - 4'h3: write and update the addressed channel(s); clears pwrdn for those channels.
  - 4'h4: set pwrdn for the addressed channel(s).
  - 4'hF: no-op.
  - Any other value: no-op.
- An update clears pwrdn on every channel it updates.
- States:
  - IDLE: synced CS high. Synced CS falling edge -> SHIFT; bit count cleared; out_shift loaded with the last completed 32-bit word (0 after reset).
  - SHIFT: each synced SCK rising edge shifts MOSI into in_shift and increments the count. The count saturates at 33. Each synced SCK falling edge shifts out_shift left. Synced CS rising edge -> EXEC.
  - EXEC (one cycle): if count==32, decode and apply, latch the frame_* fields, pulse frame_valid, and store in_shift as the echo word. Otherwise pulse frame_err and change no register. -> IDLE.
- DAC_OUT = out_shift[31] while synced CS is low; 0 otherwise.
- Synced DAC_CLR low: all input and DAC registers go to RESET_CODE and pwrdn goes to 0. From any state the FSM -> IDLE without executing; frame_valid and frame_err are not pulsed. SPI edges are ignored while CLR is low.
- RST: FSM -> IDLE; all registers go to RESET_CODE or 0; echo word 0. Every output is 0 except dac_value = {4{RESET_CODE}}.
- CS rising and an SCK edge in the same sampled cycle: the SCK edge is ignored and the CS rise takes effect.

## Timing
- Input latency: SYNC_STAGES cycles through the synchronizer plus 1 cycle for edge detection.
- frame_valid/frame_err and the register updates appear together, SYNC_STAGES+2 cycles after the raw CS rise.
- DAC_OUT is valid SYNC_STAGES+2 cycles after the raw SCK falling edge. The first bit is valid SYNC_STAGES+2 cycles after the raw CS fall.
- SCK high and low phases must each be at least SYNC_STAGES+2 CLK50MHZ cycles. CS must stay high at least 2 cycles between frames.

## Test plan
- Frame W=32'h8_ABC_0_3_01 (data 12'hABC, addr 0, cmd 3) -> frame_valid pulses once; dac_value[11:0]=12'hABC; other channels stay at RESET_CODE.
- Frame with cmd 0, addr 2, data 12'h123, then cmd 1, addr 2 -> dac_value[35:24] stays 12'h000 after the first frame and becomes 12'h123 after the second.
- CS released after 31 bits -> frame_err pulses; dac_value is unchanged; the next 32-bit frame is accepted normally.
- Two back-to-back frames -> DAC_OUT during the second frame replays the first frame's 32 bits MSB first; DAC_OUT during the first frame after reset is all 0.
- DAC_CLR pulsed low mid-frame after A=12'hFFF -> dac_value=0; no frame_valid; the interrupted frame has no effect.
- RST asserted mid-frame with addr 4'hF, cmd 3 pending -> all outputs return to reset values immediately; no pulse on release.

Source files
------------

// File: rtl/dac_responder.sv
// SPI responder modelling the DAC end of the 4-channel DAC link: decodes 32-bit frames
// into per-channel input/DAC registers and echoes the previous frame on DAC_OUT.
module dac_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [11:0] RESET_CODE  = 12'h000
) (
   input  logic        CLK50MHZ,
   input  logic        RST,
   input  logic        SPI_SCK,
   input  logic        SPI_MOSI,
   input  logic        DAC_CS,
   input  logic        DAC_CLR,
   output logic        DAC_OUT,
   output logic [47:0] dac_value,
   output logic [3:0]  pwrdn,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [3:0]  frame_cmd,
   output logic [3:0]  frame_addr,
   output logic [11:0] frame_data
);

   typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_clr_sync;
   logic                   r_sck_d;
   logic                   r_cs_d;
   logic [31:0]            r_in_shift;
   logic [31:0]            r_out_shift;
   logic [31:0]            r_echo;
   logic [5:0]             r_count;
   logic [11:0]            r_in  [4];
   logic [11:0]            r_dac [4];
   logic [3:0]             r_pwrdn;
   logic                   r_valid;
   logic                   r_err;
   logic [3:0]             r_cmd;
   logic [3:0]             r_addr;
   logic [11:0]            r_data;
   logic                   r_dac_out;

   logic       w_sck, w_mosi, w_cs, w_clr;
   logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic       w_load, w_shift_in, w_shift_out, w_exec;
   logic [3:0] w_mask;
   logic [3:0] w_cmd;
   logic [3:0] w_addr;
   logic [11:0] w_data;

   // Synchronizers idle at the inactive level so reset release creates no false edges
   always_ff @(posedge CLK50MHZ or posedge RST) begin
      if (RST) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_clr_sync  <= '1;
         r_sck_d     <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], DAC_CS};
         r_clr_sync  <= {r_clr_sync[SYNC_STAGES-2:0], DAC_CLR};
         r_sck_d     <= w_sck;
         r_cs_d      <= w_cs;
      end
   end

   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs       = r_cs_sync[SYNC_STAGES-1];
   assign w_clr      = ~r_clr_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck & ~r_sck_d;
   assign w_sck_fall = ~w_sck & r_sck_d;
   assign w_cs_rise  = w_cs & ~r_cs_d;
   assign w_cs_fall  = ~w_cs & r_cs_d;

   assign w_data = r_in_shift[27:16];
   assign w_addr = r_in_shift[15:12];
   assign w_cmd  = r_in_shift[11:8];

   always_comb begin
      w_mask = 4'h0;
      if (w_addr < 4'd4)
         w_mask[w_addr[1:0]] = 1'b1;
      else if (w_addr == 4'hF)
         w_mask = 4'hF;
   end

   always_ff @(posedge CLK50MHZ or posedge RST) begin
      if (RST)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // A CS rise in the same cycle as an SCK edge wins; the SCK edge is dropped
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_shift_in  = 1'b0;
      w_shift_out = 1'b0;
      w_exec      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_clr && w_cs_fall) begin
               w_next = SHIFT;
               w_load = 1'b1;
            end
         end
         SHIFT: begin
            if (w_clr)
               w_next = IDLE;
            else if (w_cs_rise)
               w_next = EXEC;
            else begin
               w_shift_in  = w_sck_rise;
               w_shift_out = w_sck_fall;
            end
         end
         EXEC: begin
            w_next = IDLE;
            w_exec = ~w_clr;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK50MHZ or posedge RST) begin
      if (RST) begin
         r_in_shift  <= '0;
         r_out_shift <= '0;
         r_echo      <= '0;
         r_count     <= '0;
         r_pwrdn     <= '0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_cmd       <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_dac_out   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_in[i]  <= RESET_CODE;
            r_dac[i] <= RESET_CODE;
         end
      end else begin
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_dac_out <= ~w_cs & r_out_shift[31];
         if (w_clr) begin
            r_pwrdn <= '0;
            for (int i = 0; i < 4; i++) begin
               r_in[i]  <= RESET_CODE;
               r_dac[i] <= RESET_CODE;
            end
         end else begin
            if (w_load) begin
               r_count     <= '0;
               r_out_shift <= r_echo;
            end
            if (w_shift_in) begin
               r_in_shift <= {r_in_shift[30:0], w_mosi};
               if (r_count != 6'd33)
                  r_count <= r_count + 6'd1;
            end
            if (w_shift_out)
               r_out_shift <= {r_out_shift[30:0], 1'b0};
            if (w_exec) begin
               if (r_count == 6'd32) begin
                  r_valid <= 1'b1;
                  r_cmd   <= w_cmd;
                  r_addr  <= w_addr;
                  r_data  <= w_data;
                  r_echo  <= r_in_shift;
                  // An unmapped address leaves w_mask empty, so every command is a no-op
                  for (int i = 0; i < 4; i++) begin
                     case (w_cmd)
                        4'h0: if (w_mask[i]) r_in[i] <= w_data;
                        4'h1: if (w_mask[i]) begin
                           r_dac[i]   <= r_in[i];
                           r_pwrdn[i] <= 1'b0;
                        end
                        4'h2: if (w_mask != 4'h0) begin
                           if (w_mask[i]) r_in[i] <= w_data;
                           r_dac[i]   <= w_mask[i] ? w_data : r_in[i];
                           r_pwrdn[i] <= 1'b0;
                        end
                        4'h3: if (w_mask[i]) begin
                           r_in[i]    <= w_data;
                           r_dac[i]   <= w_data;
                           r_pwrdn[i] <= 1'b0;
                        end
                        4'h4: if (w_mask[i]) r_pwrdn[i] <= 1'b1;
                        default: ;
                     endcase
                  end
               end else begin
                  r_err <= 1'b1;
               end
            end
         end
      end
   end

   assign DAC_OUT     = r_dac_out;
   assign dac_value   = {r_dac[3], r_dac[2], r_dac[1], r_dac[0]};
   assign pwrdn       = r_pwrdn;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;
   assign frame_cmd   = r_cmd;
   assign frame_addr  = r_addr;
   assign frame_data  = r_data;

endmodule

// File: tb/tb_dac_responder.sv
// Scoreboard bench for dac_responder: directed SPI frames with hand-computed expected
// register states, checked whenever the DUT pulses frame_valid or frame_err.
module tb_dac_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        mosi = 1'b0;
   logic        cs = 1'b1;
   logic        clr = 1'b1;
   logic        dac_out;
   logic [47:0] dac_value;
   logic [3:0]  pwrdn;
   logic        frame_valid;
   logic        frame_err;
   logic [3:0]  frame_cmd;
   logic [3:0]  frame_addr;
   logic [11:0] frame_data;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        err;
      logic [3:0]  cmd;
      logic [3:0]  addr;
      logic [11:0] data;
      logic [47:0] dac;
      logic [3:0]  pwrdn;
   } exp_t;

   exp_t sb[$];

   dac_responder dut (
      .CLK50MHZ    (clk),
      .RST         (rst),
      .SPI_SCK     (sck),
      .SPI_MOSI    (mosi),
      .DAC_CS      (cs),
      .DAC_CLR     (clr),
      .DAC_OUT     (dac_out),
      .dac_value   (dac_value),
      .pwrdn       (pwrdn),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .frame_cmd   (frame_cmd),
      .frame_addr  (frame_addr),
      .frame_data  (frame_data)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && (frame_valid || frame_err)) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got valid=%b err=%b expected none", frame_valid, frame_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind", {62'd0, frame_valid, frame_err}, {62'd0, ~e.err, e.err});
            chk("frame_fields", {44'd0, frame_cmd, frame_addr, frame_data}, {44'd0, e.cmd, e.addr, e.data});
            chk("dac_value", {16'd0, dac_value}, {16'd0, e.dac});
            chk("pwrdn", {60'd0, pwrdn}, {60'd0, e.pwrdn});
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [31:0] w, input int n, output logic [31:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         mosi = w[31-i];
         wait_cyc(6);
         got = {got[30:0], dac_out};
         sck = 1'b1;
         wait_cyc(6);
         sck = 1'b0;
      end
   endtask

   task automatic send(input string name, input logic [31:0] w, input int n,
                       input logic [31:0] echo_exp, input exp_t e);
      logic [31:0] got;
      sb.push_back(e);
      cs = 1'b0;
      wait_cyc(6);
      shift_bits(w, n, got);
      chk({name, "_echo"}, {32'd0, got}, {32'd0, echo_exp >> (32 - n)});
      wait_cyc(6);
      cs = 1'b1;
      wait_cyc(12);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] dummy;
      wait_cyc(4);
      chk("rst_dac_value", {16'd0, dac_value}, 64'd0);
      chk("rst_outputs", {45'd0, dac_out, pwrdn, frame_valid, frame_err, frame_cmd, frame_addr},
          64'd0);
      chk("rst_frame_data", {52'd0, frame_data}, 64'd0);
      rst = 1'b0;
      wait_cyc(6);

      send("f1_wr_upd_a", 32'h8ABC0301, 32, 32'h0,
           '{1'b0, 4'h3, 4'h0, 12'hABC, 48'h000_000_000_ABC, 4'h0});
      send("f2_wr_c", 32'h01232000, 32, 32'h8ABC0301,
           '{1'b0, 4'h0, 4'h2, 12'h123, 48'h000_000_000_ABC, 4'h0});
      send("f3_upd_c", 32'h00002100, 32, 32'h01232000,
           '{1'b0, 4'h1, 4'h2, 12'h000, 48'h000_123_000_ABC, 4'h0});
      send("f4_short", 32'h0FFF3F00, 31, 32'h00002100,
           '{1'b1, 4'h1, 4'h2, 12'h000, 48'h000_123_000_ABC, 4'h0});
      send("f5_pwrdn_b", 32'h00001400, 32, 32'h00002100,
           '{1'b0, 4'h4, 4'h1, 12'h000, 48'h000_123_000_ABC, 4'b0010});
      send("f6_wr_d_upd_all", 32'h04563200, 32, 32'h00001400,
           '{1'b0, 4'h2, 4'h3, 12'h456, 48'h456_123_000_ABC, 4'h0});
      send("f7_bad_addr", 32'h07775300, 32, 32'h04563200,
           '{1'b0, 4'h3, 4'h5, 12'h777, 48'h456_123_000_ABC, 4'h0});
      send("f8_a_fff", 32'h0FFF0300, 32, 32'h07775300,
           '{1'b0, 4'h3, 4'h0, 12'hFFF, 48'h456_123_000_FFF, 4'h0});

      // Clear mid-frame: interrupted all-channel write must vanish, no pulse
      cs = 1'b0;
      wait_cyc(6);
      shift_bits(32'h0555F300, 16, dummy);
      clr = 1'b0;
      wait_cyc(8);
      cs = 1'b1;
      wait_cyc(8);
      clr = 1'b1;
      wait_cyc(12);
      chk("clr_dac_value", {16'd0, dac_value}, 64'd0);
      chk("clr_pwrdn", {60'd0, pwrdn}, 64'd0);

      send("f9_all_321", 32'h0321F300, 32, 32'h0FFF0300,
           '{1'b0, 4'h3, 4'hF, 12'h321, {4{12'h321}}, 4'h0});

      // Reset mid-frame with an all-channel write pending
      cs = 1'b0;
      wait_cyc(6);
      shift_bits(32'h0AAAF300, 20, dummy);
      rst = 1'b1;
      #1;
      chk("rstmid_dac_value", {16'd0, dac_value}, 64'd0);
      chk("rstmid_outputs", {45'd0, dac_out, pwrdn, frame_valid, frame_err, frame_cmd, frame_addr},
          64'd0);
      chk("rstmid_frame_data", {52'd0, frame_data}, 64'd0);
      @(negedge clk);
      cs = 1'b1;
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(12);

      send("f10_after_rst", 32'h09A51300, 32, 32'h0,
           '{1'b0, 4'h3, 4'h1, 12'h9A5, 48'h000_000_9A5_000, 4'h0});

      wait_cyc(10);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
